// File: rtl/bp_fe_fetch_ctrl.sv
// rtl/bp_fe_fetch_ctrl.sv - frontend fetch sequencing: next-PC source arbitration and I$/ITLB miss recovery FSM.
// Optional miss-wait watchdog enabled by defining BP_FE_FETCH_CTRL_TIMEOUT_EN.
module bp_fe_fetch_ctrl #(
  parameter int                       vaddr_width_p    = 39,
  parameter logic [vaddr_width_p-1:0] boot_pc_p        = 39'h0080000000,
  parameter int                       timeout_cycles_p = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fe_cmd_v_i,
  input  logic [vaddr_width_p-1:0] fe_cmd_pc_i,
  output logic                     fe_cmd_ready_o,
  input  logic                     icache_ready_i,
  input  logic                     icache_miss_i,
  input  logic                     tlb_miss_i,
  input  logic                     fe_queue_ready_i,
  input  logic [vaddr_width_p-1:0] pc_f1_i,
  input  logic [vaddr_width_p-1:0] pc_f2_i,
  output logic [1:0]               pc_sel_o,
  output logic [vaddr_width_p-1:0] pc_o,
  output logic                     advance_o,
  output logic                     squash_o,
  output logic [2:0]               state_o,
  output logic                     timeout_o
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    IMISS  = 3'd2,
    TMISS  = 3'd3,
    REPLAY = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [vaddr_width_p-1:0] replay_pc_q, replay_pc_d;
  logic                     stall, accept, timeout_fire;

  assign stall          = ~fe_queue_ready_i | ~icache_ready_i;
  assign fe_cmd_ready_o = (state_q != BOOT) & icache_ready_i & ~icache_miss_i & ~tlb_miss_i;
  assign accept         = fe_cmd_v_i & fe_cmd_ready_o;
  assign state_o        = state_q;

`ifdef BP_FE_FETCH_CTRL_TIMEOUT_EN
  localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_limit_lp = cnt_width_lp'(timeout_cycles_p);

  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    in_miss;

  assign in_miss      = (state_q == IMISS) | (state_q == TMISS);
  assign timeout_fire = in_miss & ((cnt_q + cnt_width_lp'(1)) == cnt_limit_lp);
  assign timeout_o    = timeout_fire;

  always_comb begin
    cnt_d = '0;
    if (in_miss) begin
      cnt_d = (cnt_q == cnt_limit_lp) ? cnt_q : cnt_q + cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    replay_pc_d = replay_pc_q;
    pc_sel_o    = 2'd0;
    pc_o        = '0;
    advance_o   = 1'b0;
    squash_o    = 1'b0;

    if (state_q == BOOT) begin
      pc_sel_o  = 2'd3;
      pc_o      = boot_pc_p;
      advance_o = icache_ready_i;
      squash_o  = 1'b1;
      if (icache_ready_i) state_d = RUN;
    end else if (accept) begin
      // Redirect wins over everything and drops any pending replay.
      pc_sel_o  = 2'd1;
      pc_o      = fe_cmd_pc_i;
      advance_o = 1'b1;
      squash_o  = 1'b1;
      state_d   = RUN;
    end else begin
      unique case (state_q)
        RUN, REPLAY: begin
          if (tlb_miss_i) begin
            replay_pc_d = pc_f1_i;
            squash_o    = 1'b1;
            state_d     = TMISS;
          end else if (icache_miss_i) begin
            replay_pc_d = pc_f2_i;
            squash_o    = 1'b1;
            state_d     = IMISS;
          end else if (state_q == RUN) begin
            advance_o = ~stall;
          end else begin
            pc_sel_o  = 2'd2;
            pc_o      = replay_pc_q;
            advance_o = icache_ready_i & fe_queue_ready_i;
            if (advance_o) state_d = RUN;
          end
        end
        // f1 was already squashed on entry, so a TLB miss here is not tracked.
        IMISS: if (!icache_miss_i) state_d = REPLAY;
        TMISS: if (!tlb_miss_i) state_d = REPLAY;
        default: state_d = BOOT;
      endcase
      if (timeout_fire) state_d = REPLAY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= BOOT;
      replay_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      replay_pc_q <= replay_pc_d;
    end
  end

endmodule

// File: tb/tb_bp_fe_fetch_ctrl.sv
// tb/tb_bp_fe_fetch_ctrl.sv - directed-vector scoreboard bench for bp_fe_fetch_ctrl.
module tb_bp_fe_fetch_ctrl;

  localparam logic [38:0] BOOT_PC = 39'h0080000000;
  localparam logic [38:0] F1_PC   = 39'h2004;

  logic        clk = 1'b0;
  logic        reset;
  logic        fe_cmd_v;
  logic [38:0] fe_cmd_pc;
  logic        fe_cmd_ready;
  logic        icache_ready, icache_miss, tlb_miss, fe_queue_ready;
  logic [38:0] pc_f1, pc_f2;
  logic [1:0]  pc_sel;
  logic [38:0] pc;
  logic        advance, squash, timeout;
  logic [2:0]  state;

  always #5 clk = ~clk;

  bp_fe_fetch_ctrl #(
    .vaddr_width_p   (39),
    .boot_pc_p       (BOOT_PC),
    .timeout_cycles_p(8)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .fe_cmd_v_i      (fe_cmd_v),
    .fe_cmd_pc_i     (fe_cmd_pc),
    .fe_cmd_ready_o  (fe_cmd_ready),
    .icache_ready_i  (icache_ready),
    .icache_miss_i   (icache_miss),
    .tlb_miss_i      (tlb_miss),
    .fe_queue_ready_i(fe_queue_ready),
    .pc_f1_i         (pc_f1),
    .pc_f2_i         (pc_f2),
    .pc_sel_o        (pc_sel),
    .pc_o            (pc),
    .advance_o       (advance),
    .squash_o        (squash),
    .state_o         (state),
    .timeout_o       (timeout)
  );

  typedef struct {
    logic        rst, cv;
    logic [38:0] cpc;
    logic        ir, im, tm, qr;
    logic [38:0] f2;
    logic [2:0]  st;
    logic [1:0]  sel;
    logic [38:0] pc;
    logic        adv, sq, rdy, to;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_seen = 0;

  function automatic void v(input logic rst, input logic cv, input logic [38:0] cpc,
                            input logic ir, input logic im, input logic tm, input logic qr,
                            input logic [38:0] f2, input logic [2:0] st, input logic [1:0] sel,
                            input logic [38:0] epc, input logic adv, input logic sq,
                            input logic rdy, input logic to);
    vec_t t;
    t.rst = rst; t.cv = cv; t.cpc = cpc; t.ir = ir; t.im = im; t.tm = tm; t.qr = qr;
    t.f2 = f2; t.st = st; t.sel = sel; t.pc = epc; t.adv = adv; t.sq = sq; t.rdy = rdy; t.to = to;
    vecs.push_back(t);
  endfunction

  // Monitor: one expected response per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      n_run++;
      if ({state, pc_sel, pc, advance, squash, fe_cmd_ready, timeout} !==
          {e.st, e.sel, e.pc, e.adv, e.sq, e.rdy, e.to}) begin
        n_fail++;
        $display("FAIL vec%0d: got st=%0d sel=%0d pc=%h adv=%b sq=%b rdy=%b to=%b, want st=%0d sel=%0d pc=%h adv=%b sq=%b rdy=%b to=%b",
                 n_seen, state, pc_sel, pc, advance, squash, fe_cmd_ready, timeout,
                 e.st, e.sel, e.pc, e.adv, e.sq, e.rdy, e.to);
      end
      n_seen++;
    end
  end

  initial begin
    //  rst cv cpc       ir im tm qr f2        st sel pc        adv sq rdy to
    v(1, 0, 39'h0,    0, 0, 0, 1, 39'h0,    0, 3, BOOT_PC, 0, 1, 0, 0);  // reset state
    v(0, 1, 39'h9000, 0, 0, 0, 1, 39'h0,    0, 3, BOOT_PC, 0, 1, 0, 0);  // cmd ignored in BOOT
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    0, 3, BOOT_PC, 1, 1, 0, 0);  // boot issue
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    1, 0, 39'h0,   1, 0, 1, 0);  // RUN
    v(0, 0, 39'h0,    1, 0, 0, 0, 39'h0,    1, 0, 39'h0,   0, 0, 1, 0);  // queue full stall
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h1000, 1, 0, 39'h0,   0, 1, 0, 0);  // I$ miss detect
    for (int i = 0; i < 4; i++)
      v(0, 0, 39'h0,  1, 1, 0, 1, 39'h1000, 2, 0, 39'h0,   0, 0, 0, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h1000, 2, 0, 39'h0,   0, 0, 1, 0);  // 5th IMISS, miss low
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    4, 2, 39'h1000,1, 0, 1, 0);  // replay 0x1000
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    1, 0, 39'h0,   1, 0, 1, 0);
    v(0, 0, 39'h0,    1, 1, 1, 1, 39'h1000, 1, 0, 39'h0,   0, 1, 0, 0);  // both misses -> TMISS
    v(0, 0, 39'h0,    1, 0, 1, 1, 39'h0,    3, 0, 39'h0,   0, 0, 0, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    3, 0, 39'h0,   0, 0, 1, 0);
    v(0, 0, 39'h0,    1, 0, 0, 0, 39'h0,    4, 2, F1_PC,   0, 0, 1, 0);  // replay held by full queue
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    4, 2, F1_PC,   1, 0, 1, 0);
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h3008, 1, 0, 39'h0,   0, 1, 0, 0);
    v(0, 0, 39'h0,    1, 1, 1, 1, 39'h0,    2, 0, 39'h0,   0, 0, 0, 0);  // tlb ignored in IMISS
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    2, 0, 39'h0,   0, 0, 1, 0);
    v(0, 1, 39'h4000, 1, 0, 0, 1, 39'h0,    4, 1, 39'h4000,1, 1, 1, 0);  // redirect beats replay
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    1, 0, 39'h0,   1, 0, 1, 0);
    v(0, 1, 39'h5000, 1, 0, 0, 1, 39'h0,    1, 1, 39'h5000,1, 1, 1, 0);  // redirect in RUN
    v(0, 1, 39'h5000, 0, 0, 0, 1, 39'h0,    1, 0, 39'h0,   0, 0, 0, 0);  // I$ busy blocks redirect
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h6000, 1, 0, 39'h0,   0, 1, 0, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    2, 0, 39'h0,   0, 0, 1, 0);
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h7000, 4, 0, 39'h0,   0, 1, 0, 0);  // new miss in REPLAY
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    2, 0, 39'h0,   0, 0, 1, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    4, 2, 39'h7000,1, 0, 1, 0);
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h7000, 1, 0, 39'h0,   0, 1, 0, 0);
    v(1, 0, 39'h0,    1, 1, 0, 1, 39'h0,    2, 0, 39'h0,   0, 0, 0, 0);  // reset mid-miss
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    0, 3, BOOT_PC, 1, 1, 0, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    1, 0, 39'h0,   1, 0, 1, 0);
`ifdef BP_FE_FETCH_CTRL_TIMEOUT_EN
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h8000, 1, 0, 39'h0,   0, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      v(0, 0, 39'h0,  1, 1, 0, 1, 39'h8000, 2, 0, 39'h0,   0, 0, 0, 0);
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h8000, 2, 0, 39'h0,   0, 0, 0, 1);  // 8th IMISS cycle fires
    v(0, 0, 39'h0,    1, 1, 0, 1, 39'h8000, 4, 0, 39'h0,   0, 1, 0, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    2, 0, 39'h0,   0, 0, 1, 0);
    v(0, 0, 39'h0,    1, 0, 0, 1, 39'h0,    4, 2, 39'h8000,1, 0, 1, 0);
`endif

    reset = 1'b1; fe_cmd_v = 1'b0; fe_cmd_pc = '0; icache_ready = 1'b0;
    icache_miss = 1'b0; tlb_miss = 1'b0; fe_queue_ready = 1'b1;
    pc_f1 = F1_PC; pc_f2 = '0;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst; fe_cmd_v = vecs[i].cv; fe_cmd_pc = vecs[i].cpc;
      icache_ready = vecs[i].ir; icache_miss = vecs[i].im; tlb_miss = vecs[i].tm;
      fe_queue_ready = vecs[i].qr; pc_f2 = vecs[i].f2;
      exp_q.push_back(vecs[i]);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d responses unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
